// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes and controller state encoding for the LCD image controller.
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE  = 4'h0;
    localparam logic [3:0] CMD_UP     = 4'h1;
    localparam logic [3:0] CMD_DOWN   = 4'h2;
    localparam logic [3:0] CMD_LEFT   = 4'h3;
    localparam logic [3:0] CMD_RIGHT  = 4'h4;
    localparam logic [3:0] CMD_MAX    = 4'h5;
    localparam logic [3:0] CMD_MIN    = 4'h6;
    localparam logic [3:0] CMD_AVG    = 4'h7;
    localparam logic [3:0] CMD_CCW    = 4'h8;
    localparam logic [3:0] CMD_CW     = 4'h9;
    localparam logic [3:0] CMD_MIRX   = 4'hA;
    localparam logic [3:0] CMD_MIRY   = 4'hB;
    localparam logic [3:0] CMD_ORIGIN = 4'hC;
    localparam logic [3:0] CMD_INV    = 4'hD;
    localparam logic [3:0] CMD_LOAD   = 4'hE;
    localparam logic [3:0] CMD_NOP    = 4'hF;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_IDLE,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/lcd_ctrl_param_win_alu.sv
// Combinational 2x2 window operator: computes the four new window pixels for a command.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] p1_i,
    input  logic [DW-1:0] p2_i,
    input  logic [DW-1:0] p3_i,
    input  logic [DW-1:0] p4_i,
    input  logic [3:0]    cmd_i,
    output logic [DW-1:0] n1_o,
    output logic [DW-1:0] n2_o,
    output logic [DW-1:0] n3_o,
    output logic [DW-1:0] n4_o
);

    localparam int unsigned SW = DW + 2;

    logic [DW-1:0] mx_a, mx_b, mx, mn_a, mn_b, mn, avg;
    logic [SW-1:0] sum;

    assign mx_a = (p1_i > p2_i) ? p1_i : p2_i;
    assign mx_b = (p3_i > p4_i) ? p3_i : p4_i;
    assign mx   = (mx_a > mx_b) ? mx_a : mx_b;
    assign mn_a = (p1_i < p2_i) ? p1_i : p2_i;
    assign mn_b = (p3_i < p4_i) ? p3_i : p4_i;
    assign mn   = (mn_a < mn_b) ? mn_a : mn_b;
    assign sum  = SW'(p1_i) + SW'(p2_i) + SW'(p3_i) + SW'(p4_i);
    assign avg  = DW'(sum >> 2);

    // Select the new window contents; commands that do not touch pixels pass them through
    always_comb begin
        n1_o = p1_i;
        n2_o = p2_i;
        n3_o = p3_i;
        n4_o = p4_i;
        case (cmd_i)
            CMD_MAX:  begin n1_o = mx;   n2_o = mx;   n3_o = mx;   n4_o = mx;   end
            CMD_MIN:  begin n1_o = mn;   n2_o = mn;   n3_o = mn;   n4_o = mn;   end
            CMD_AVG:  begin n1_o = avg;  n2_o = avg;  n3_o = avg;  n4_o = avg;  end
            CMD_CCW:  begin n1_o = p2_i; n2_o = p4_i; n3_o = p1_i; n4_o = p3_i; end
            CMD_CW:   begin n1_o = p3_i; n2_o = p1_i; n3_o = p4_i; n4_o = p2_i; end
            CMD_MIRX: begin n1_o = p3_i; n2_o = p4_i; n3_o = p1_i; n4_o = p2_i; end
            CMD_MIRY: begin n1_o = p2_i; n2_o = p1_i; n3_o = p4_i; n4_o = p3_i; end
            CMD_INV:  begin n1_o = ~p1_i; n2_o = ~p2_i; n3_o = ~p3_i; n4_o = ~p4_i; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads an image from ROM, edits a movable 2x2 window, streams the image to RAM.
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned XW = 3,
    parameter int unsigned YW = 3,
    localparam int unsigned AW = XW + YW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] rom_q,
    output logic          rom_rd,
    output logic [AW-1:0] rom_a,
    output logic          ram_valid,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          busy,
    output logic          done
);

    localparam int unsigned W = 2 ** XW;
    localparam int unsigned H = 2 ** YW;
    localparam int unsigned N = 2 ** AW;

    state_e        state_q;
    logic [3:0]    cmd_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          cap_v_q;
    logic [AW-1:0] cap_a_q;
    logic [DW-1:0] mem_q [N];

    logic [XW-1:0] xm1;
    logic [YW-1:0] ym1;
    logic [AW-1:0] i1, i2, i3, i4;
    logic [DW-1:0] n1, n2, n3, n4;

    assign xm1 = x_q - XW'(1);
    assign ym1 = y_q - YW'(1);
    assign i1  = {ym1, xm1};
    assign i2  = {ym1, x_q};
    assign i3  = {y_q, xm1};
    assign i4  = {y_q, x_q};

    lcd_win_alu #(.DW(DW)) u_alu (
        .p1_i  (mem_q[i1]),
        .p2_i  (mem_q[i2]),
        .p3_i  (mem_q[i3]),
        .p4_i  (mem_q[i4]),
        .cmd_i (cmd_q),
        .n1_o  (n1),
        .n2_o  (n2),
        .n3_o  (n3),
        .n4_o  (n4)
    );

    // Controller FSM with ROM read sequencer, RAM write sequencer and origin registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            cmd_q     <= CMD_NOP;
            x_q       <= XW'(W / 2);
            y_q       <= YW'(H / 2);
            cap_v_q   <= 1'b0;
            cap_a_q   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            rom_rd    <= 1'b0;
            rom_a     <= '0;
            ram_valid <= 1'b0;
            ram_a     <= '0;
            ram_d     <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    cap_v_q <= rom_rd;
                    cap_a_q <= rom_a;
                    if (rom_rd) begin
                        if (rom_a == AW'(N - 1)) rom_rd <= 1'b0;
                        else                     rom_a  <= rom_a + AW'(1);
                    end else if (cap_v_q) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        rom_rd <= 1'b1;
                        rom_a  <= '0;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    done    <= 1'b0;
                    state_q <= ST_IDLE;
                    if (cmd_valid) begin
                        busy  <= 1'b1;
                        cmd_q <= cmd;
                        if (cmd == CMD_WRITE) begin
                            state_q   <= ST_WRITE;
                            ram_valid <= 1'b1;
                            ram_a     <= '0;
                            ram_d     <= mem_q[0];
                        end else if (cmd == CMD_LOAD) begin
                            state_q <= ST_LOAD;
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    case (cmd_q)
                        CMD_UP:     if (y_q != YW'(1))     y_q <= y_q - YW'(1);
                        CMD_DOWN:   if (y_q != YW'(H - 1)) y_q <= y_q + YW'(1);
                        CMD_LEFT:   if (x_q != XW'(1))     x_q <= x_q - XW'(1);
                        CMD_RIGHT:  if (x_q != XW'(W - 1)) x_q <= x_q + XW'(1);
                        CMD_ORIGIN: begin
                            x_q <= XW'(W / 2);
                            y_q <= YW'(H / 2);
                        end
                        default: ;
                    endcase
                end
                ST_WRITE: begin
                    if (ram_a == AW'(N - 1)) begin
                        ram_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        ram_a <= ram_a + AW'(1);
                        ram_d <= mem_q[ram_a + AW'(1)];
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // Image buffer: ROM capture during load, window commit at the end of an execute cycle
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && cap_v_q) begin
            mem_q[cap_a_q] <= rom_q;
        end else if (state_q == ST_EXEC) begin
            mem_q[i1] <= n1;
            mem_q[i2] <= n2;
            mem_q[i3] <= n3;
            mem_q[i4] <= n4;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench for lcd_ctrl_param: default-size DUT against an image model, plus a 16x8x10-bit DUT.
module tb_lcd_ctrl_param;

    localparam int unsigned DW  = 8;
    localparam int unsigned XW  = 3;
    localparam int unsigned YW  = 3;
    localparam int unsigned AW  = XW + YW;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = 64;
    localparam int unsigned DW2 = 10;
    localparam int unsigned XW2 = 4;
    localparam int unsigned YW2 = 3;
    localparam int unsigned AW2 = XW2 + YW2;
    localparam int N2 = 128;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     cmd, cmd2;
    logic           cmd_valid, cmd_valid2;
    logic [DW-1:0]  rom_q;
    logic [DW2-1:0] rom_q2;
    logic           rom_rd, rom_rd2, ram_valid, ram_valid2, busy, busy2, done, done2;
    logic [AW-1:0]  rom_a, ram_a;
    logic [AW2-1:0] rom_a2, ram_a2;
    logic [DW-1:0]  ram_d;
    logic [DW2-1:0] ram_d2;

    logic [DW-1:0]  rom_mem  [N];
    logic [DW2-1:0] rom_mem2 [N2];

    int checks   = 0;
    int failures = 0;
    int img [N];
    int ox, oy;
    int got_w [N];
    int got2 [N2];
    int exp2 [N2];

    always #5 clk = ~clk;

    lcd_ctrl_param dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .rom_q(rom_q),
        .rom_rd(rom_rd), .rom_a(rom_a), .ram_valid(ram_valid), .ram_a(ram_a),
        .ram_d(ram_d), .busy(busy), .done(done)
    );

    lcd_ctrl_param #(.DW(DW2), .XW(XW2), .YW(YW2)) dut2 (
        .clk(clk), .reset(reset), .cmd(cmd2), .cmd_valid(cmd_valid2), .rom_q(rom_q2),
        .rom_rd(rom_rd2), .rom_a(rom_a2), .ram_valid(ram_valid2), .ram_a(ram_a2),
        .ram_d(ram_d2), .busy(busy2), .done(done2)
    );

    // Synchronous ROMs: data for the address presented this cycle appears next cycle
    always @(posedge clk) begin
        if (rom_rd)  rom_q  <= rom_mem[rom_a];
        if (rom_rd2) rom_q2 <= rom_mem2[rom_a2];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ix(input int x, input int y);
        return y * W + x;
    endfunction

    task automatic model_reload();
        for (int i = 0; i < N; i++) img[i] = int'(rom_mem[i]);
    endtask

    // Reference behaviour of one command on the image and origin
    task automatic model_cmd(input int c);
        int a[4];
        int p[4];
        int q[4];
        int m;
        a[0] = ix(ox - 1, oy - 1); a[1] = ix(ox, oy - 1);
        a[2] = ix(ox - 1, oy);     a[3] = ix(ox, oy);
        for (int i = 0; i < 4; i++) p[i] = img[a[i]];
        q = p;
        case (c)
            1:  if (oy > 1) oy--;
            2:  if (oy < H - 1) oy++;
            3:  if (ox > 1) ox--;
            4:  if (ox < W - 1) ox++;
            5:  begin m = p[0]; for (int i = 1; i < 4; i++) if (p[i] > m) m = p[i];
                      for (int i = 0; i < 4; i++) q[i] = m; end
            6:  begin m = p[0]; for (int i = 1; i < 4; i++) if (p[i] < m) m = p[i];
                      for (int i = 0; i < 4; i++) q[i] = m; end
            7:  begin m = (p[0] + p[1] + p[2] + p[3]) / 4;
                      for (int i = 0; i < 4; i++) q[i] = m; end
            8:  q = '{p[1], p[3], p[0], p[2]};
            9:  q = '{p[2], p[0], p[3], p[1]};
            10: q = '{p[2], p[3], p[0], p[1]};
            11: q = '{p[1], p[0], p[3], p[2]};
            12: begin ox = W / 2; oy = H / 2; end
            13: for (int i = 0; i < 4; i++) q[i] = (1 << DW) - 1 - p[i];
            default: ;
        endcase
        if (c == 14) model_reload();
        else for (int i = 0; i < 4; i++) img[a[i]] = q[i];
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        chk(tag, 32'(busy), 0);
    endtask

    // Checks a RAM stream word by word; optional ignored strobe or reset injected at a word
    task automatic check_write(input int inj_at, input int rst_at);
        int n;
        for (int k = 0; k < N; k++) begin
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_ram_valid", 32'(ram_valid), 0);
                chk("rst_busy", 32'(busy), 1);
                chk("rst_outs", {rom_rd, done, 6'(rom_a), 6'(ram_a), 8'(ram_d)}, 0);
                @(negedge clk);
                reset = 1'b0;
                ox = W / 2; oy = H / 2;
                model_reload();
                n = 0;
                while (!rom_rd && n < 10) begin @(negedge clk); n++; end
                chk("reload_rom_rd", 32'(rom_rd), 1);
                chk("reload_rom_a0", 32'(rom_a), 0);
                return;
            end
            got_w[k] = int'(ram_d);
            chk("ram_word", (32'(ram_valid) << 16) | (32'(ram_a) << 8) | 32'(ram_d),
                32'((1 << 16) | (k << 8) | img[k]));
            if (k == inj_at) begin cmd_valid = 1'b1; cmd = 4'($urandom); end
            else cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("done_pulse", {29'd0, ram_valid, done, busy}, 32'b010);
        @(negedge clk);
        chk("done_clear", 32'(done), 0);
    endtask

    task automatic send_x(input logic [3:0] c, input int inj_at, input int rst_at);
        wait_idle("idle_before_cmd");
        cmd = c; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd = 4'($urandom);
        chk("busy_after_accept", 32'(busy), 1);
        if (c == 4'h0) begin
            check_write(inj_at, rst_at);
        end else if (c == 4'hE) begin
            model_cmd(14);
            wait_idle("load_finish");
        end else begin
            model_cmd(int'(c));
            @(negedge clk);
            chk("busy_one_cycle", 32'(busy), 0);
        end
    endtask

    task automatic send(input logic [3:0] c);
        send_x(c, -1, -1);
    endtask

    task automatic send2(input logic [3:0] c);
        int n = 0;
        while (busy2 && n < 400) begin @(negedge clk); n++; end
        cmd2 = c; cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        n = 0;
        while (busy2 && n < 400) begin @(negedge clk); n++; end
        chk("dut2_cmd_idle", 32'(busy2), 0);
    endtask

    initial begin
        int c1, c2, err, n;
        logic [3:0] rc;
        reset = 1'b1; cmd = '0; cmd_valid = 1'b0; cmd2 = '0; cmd_valid2 = 1'b0;
        for (int i = 0; i < N; i++)  rom_mem[i]  = DW'(i);
        for (int i = 0; i < N2; i++) rom_mem2[i] = DW2'(i);
        #1;
        chk("reset_busy", {30'd0, busy, busy2}, 3);
        chk("reset_outs", {done, rom_rd, ram_valid, 6'(rom_a), 6'(ram_a), 8'(ram_d)}, 0);
        chk("reset_outs2", {done2, rom_rd2, ram_valid2, 7'(rom_a2), 7'(ram_a2), 10'(ram_d2)}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ox = W / 2; oy = H / 2;
        model_reload();

        // Initial load on both DUTs: read cycles and address sequence
        c1 = 0; c2 = 0; err = 0; n = 0;
        while ((busy || busy2) && n < 400) begin
            @(negedge clk);
            if (rom_rd)  begin if (int'(rom_a)  != c1) err++; c1++; end
            if (rom_rd2) begin if (int'(rom_a2) != c2) err++; c2++; end
            n++;
        end
        chk("load_cycles", 32'(c1), N);
        chk("load_cycles2", 32'(c2), N2);
        chk("load_addr_seq", 32'(err), 0);
        chk("load_rom_rd_off", {30'd0, rom_rd, rom_rd2}, 0);

        // Max at centre then write
        send(4'h5); send(4'h0);
        chk("max_p1", 32'(got_w[27]), 36);
        chk("max_p4", 32'(got_w[36]), 36);
        chk("max_other", 32'(got_w[26]), 26);

        // Saturating moves to the corner, then average
        send(4'hE);
        repeat (5) send(4'h3);
        repeat (5) send(4'h1);
        chk("corner_origin", 32'((ox << 8) | oy), 32'((1 << 8) | 1));
        send(4'h7); send(4'h0);
        chk("avg_p1", 32'(got_w[0]), 4);
        chk("avg_p4", 32'(got_w[9]), 4);
        chk("avg_other", 32'(got_w[10]), 10);

        // CW rotate at centre, then CCW restores identity
        send(4'hE); send(4'hC); send(4'h9); send(4'h0);
        chk("cw_27", 32'(got_w[27]), 35);
        chk("cw_28", 32'(got_w[28]), 27);
        chk("cw_35", 32'(got_w[35]), 36);
        chk("cw_36", 32'(got_w[36]), 28);
        send(4'h8); send(4'h0);
        chk("ccw_restore", 32'(got_w[35]), 35);

        // Strobe during write is ignored
        send_x(4'h0, int'($urandom_range(1, N - 2)), -1);
        send(4'h0);

        // Reset part-way through a write
        send(4'h2); send(4'h4);
        send_x(4'h0, -1, 30);
        send(4'hD); send(4'h0);
        chk("post_reset_centre", 32'(got_w[36]), 255 - 36);

        // Invert, mirror, reload: original image returns
        send(4'hD); send(4'hB); send(4'hE); send(4'h0);
        chk("reload_orig", 32'(got_w[27]), 27);

        // Randomised image and command stream
        for (int i = 0; i < N; i++) rom_mem[i] = DW'($urandom);
        send(4'hE);
        for (int t = 0; t < 300; t++) begin
            rc = 4'($urandom_range(0, 15));
            send(rc);
        end
        send(4'h0);

        // Wider, non-square instance: Right saturation and invert at two positions
        for (int i = 0; i < N2; i++) exp2[i] = i;
        repeat (20) send2(4'h4);
        send2(4'hD);
        foreach (exp2[i]) if (i == 62 || i == 63 || i == 78 || i == 79) exp2[i] = 1023 - i;
        repeat (3) send2(4'h1);
        repeat (10) send2(4'h3);
        send2(4'hD);
        foreach (exp2[i]) if (i == 4 || i == 5 || i == 20 || i == 21) exp2[i] = 1023 - i;
        cmd2 = 4'h0; cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        for (int k = 0; k < N2; k++) begin
            got2[k] = int'(ram_d2);
            chk("dut2_word", (32'(ram_valid2) << 20) | (32'(ram_a2) << 12) | 32'(ram_d2),
                32'((1 << 20) | (k << 12) | exp2[k]));
            @(negedge clk);
        end
        chk("dut2_done", {29'd0, ram_valid2, done2, busy2}, 32'b010);
        chk("dut2_inv5", 32'(got2[5]), 1018);
        chk("dut2_inv79", 32'(got2[79]), 1023 - 79);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
